fx3_multi_thread_writer: RTL

// Parametrised GPIF-II write controller streaming the sample FIFO into N FX3 DMA threads in strict

---
 rtl/fx3_pkg.sv | 20 ++
 rtl/fx3_input_sync.sv | 22 ++
 rtl/fx3_multi_thread_writer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fx3_pkg.sv
// Shared FX3 GPIF definitions: write-controller state encoding, default
// thread-address width and a counter-width helper.
package fx3_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    WAIT_WM = 3'd2,
    SEND    = 3'd3,
    DELAY   = 3'd4
  } fx3_state_t;

  localparam int FX3_ADDR_W = 2;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fx3_input_sync.sv
// Single register stage for FX3 pin inputs; decisions downstream only ever
// see the captured copy, never the raw pins.
module fx3_input_sync #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // capture stage
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/fx3_multi_thread_writer.sv
// GPIF-II write controller: drains the sample FIFO into FX3 DMA threads in
// strict round-robin order, ending each burst on watermark, word count or underrun.
module fx3_multi_thread_writer
  import fx3_pkg::*;
#(
  parameter int NUM_THREADS   = 2,
  parameter int ADDR_W        = FX3_ADDR_W,
  parameter int BURST_WORDS   = 8192,
  parameter int USE_WATERMARK = 1,
  parameter int DELAY_CYCLES  = 1,
  parameter int ADDR_SETUP    = 1
) (
  input  logic                   fx3_clock,
  input  logic                   fx3_reset,
  input  logic                   fx3_nReady,
  input  logic [NUM_THREADS-1:0] fx3_threadReady,
  input  logic [NUM_THREADS-1:0] fx3_threadWatermark,
  input  logic                   fifoHalfFull,
  input  logic                   fifoEmpty,
  output logic                   fx3_nWrite,
  output logic [ADDR_W-1:0]      fx3_threadAddr,
  output logic                   fifoRead,
  output logic                   underrunFlag,
  output logic                   burstActive
);

  localparam int CNT_W  = cnt_width(BURST_WORDS);
  localparam int CUR_W  = cnt_width(NUM_THREADS);
  localparam int TMR_W  = cnt_width(DELAY_CYCLES + ADDR_SETUP + 1);
  localparam int SYNC_W = 2 * NUM_THREADS + 1;

  localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(BURST_WORDS - 1);
  localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(ADDR_SETUP - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(DELAY_CYCLES - 1);
  localparam logic [CUR_W-1:0] LAST_CUR   = CUR_W'(NUM_THREADS - 1);

  logic [SYNC_W-1:0]      sync_d;
  logic [SYNC_W-1:0]      sync_q;
  logic                   nready_q;
  logic [NUM_THREADS-1:0] thread_ready_q;
  logic [NUM_THREADS-1:0] watermark_q;

  fx3_state_t       state;
  fx3_state_t       state_nx;
  logic [CUR_W-1:0] cur;
  logic [CUR_W-1:0] cur_nx;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] word_cnt_nx;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmr_nx;
  logic             underrun_nx;
  logic             load_addr;

  // nReady resets high so nothing is armed before the first real sample
  assign sync_d = {fx3_nReady, fx3_threadReady, fx3_threadWatermark};

  fx3_input_sync #(
    .W       (SYNC_W),
    .RST_VAL ({1'b1, {(2 * NUM_THREADS){1'b0}}})
  ) u_input_sync (
    .clk (fx3_clock),
    .rst (fx3_reset),
    .d   (sync_d),
    .q   (sync_q)
  );

  assign nready_q       = sync_q[SYNC_W-1];
  assign thread_ready_q = sync_q[2*NUM_THREADS-1:NUM_THREADS];
  assign watermark_q    = sync_q[NUM_THREADS-1:0];

  assign load_addr = (state_nx == SETUP) && (state != SETUP);

  // next-state, counters and sticky underrun
  always_comb begin
    state_nx    = state;
    cur_nx      = cur;
    word_cnt_nx = word_cnt;
    tmr_nx      = tmr;
    underrun_nx = underrunFlag;
    case (state)
      IDLE: begin
        if (thread_ready_q[cur] && fifoHalfFull && !nready_q) begin
          state_nx = SETUP;
          tmr_nx   = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      SETUP: begin
        if (tmr == SETUP_LAST) begin
          tmr_nx   = '0;
          state_nx = (USE_WATERMARK != 0) ? WAIT_WM : SEND;
        end else begin
          tmr_nx = tmr + 1'b1;
        end
      end
      WAIT_WM: begin
        if (watermark_q[cur]) begin
          state_nx = SEND;
        end else begin
          state_nx = WAIT_WM;
        end
      end
      SEND: begin
        // underrun is checked independently so a coincident count end still flags it
        if (fifoEmpty || ((USE_WATERMARK != 0) && !watermark_q[cur]) || (word_cnt == LAST_WORD)) begin
          state_nx    = DELAY;
          tmr_nx      = '0;
          underrun_nx = underrunFlag | fifoEmpty;
        end else begin
          word_cnt_nx = word_cnt + 1'b1;
        end
      end
      DELAY: begin
        word_cnt_nx = '0;
        if (tmr == DELAY_LAST) begin
          tmr_nx   = '0;
          state_nx = IDLE;
          cur_nx   = (cur == LAST_CUR) ? '0 : cur + 1'b1;
        end else begin
          tmr_nx = tmr + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // state, counters and registered pin outputs (one cycle behind state)
  always_ff @(posedge fx3_clock) begin
    if (fx3_reset) begin
      state          <= IDLE;
      cur            <= '0;
      word_cnt       <= '0;
      tmr            <= '0;
      underrunFlag   <= 1'b0;
      fx3_nWrite     <= 1'b1;
      fifoRead       <= 1'b0;
      burstActive    <= 1'b0;
      fx3_threadAddr <= '0;
    end else begin
      state        <= state_nx;
      cur          <= cur_nx;
      word_cnt     <= word_cnt_nx;
      tmr          <= tmr_nx;
      underrunFlag <= underrun_nx;
      fx3_nWrite   <= (state != SEND);
      fifoRead     <= (state == SEND);
      burstActive  <= (state == SEND);
      if (load_addr) begin
        fx3_threadAddr <= ADDR_W'(cur);
      end else begin
        fx3_threadAddr <= fx3_threadAddr;
      end
    end
  end

endmodule
